// File: rtl/shift_add_mul_if.sv
// rtl/shift_add_mul_if.sv - handshake/operand/result bundle for shift_add_mul
// Signals:
//   start         request to begin a multiply (master -> slave)
//   a, b          32-bit multiplicand / multiplier (master -> slave)
//   busy          slave is in RUN or DONE (slave -> master)
//   done          one-cycle pulse when product is updated (slave -> master)
//   product       64-bit registered result (slave -> master)
interface shift_add_mul_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mul.sv
// rtl/shift_add_mul.sv - 32x32 sequential shift-add multiplier, 64-bit result
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears every register
//   bus    shift_add_mul_if.slave: start/a/b in, busy/done/product out
// Build option: define SHIFT_ADD_MUL_SIGNED_EN for two's-complement operands
// and product; undefined gives unsigned operation. Timing is identical.
// Also contains cla, the 32-bit carry-lookahead adder used by the datapath.

module cla (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g;
  logic [31:0] p;

  assign g = x & y;
  assign p = x ^ y;

  // 4-bit lookahead groups; the group carry chains between groups.
  always_comb begin
    logic       c0;
    logic [3:0] gg;
    logic [3:0] pp;
    logic [3:0] c;
    sum = '0;
    c0  = cin;
    for (int k = 0; k < 8; k++) begin
      gg   = g[4*k +: 4];
      pp   = p[4*k +: 4];
      c[0] = c0;
      c[1] = gg[0] | (pp[0] & c0);
      c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
      c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
           | (pp[2] & pp[1] & pp[0] & c0);
      c0   = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
           | (pp[3] & pp[2] & pp[1] & gg[0]) | (pp[3] & pp[2] & pp[1] & pp[0] & c0);
      sum[4*k +: 4] = pp ^ c;
    end
    cout = c0;
  end
endmodule

module shift_add_mul (
  input  logic           clk,
  input  logic           rst_n,
  shift_add_mul_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] m;
  logic [63:0] p;
  logic [5:0]  cnt;        // 6 bits so it never wraps during the 32 iterations
  logic [63:0] product_q;
  logic [31:0] add_y;
  logic [31:0] add_sum;
  logic        add_cout;
  logic [63:0] p_nxt;
  logic [63:0] result;
  logic [31:0] a_ld;
  logic [31:0] b_ld;
  logic        last_iter;

  assign last_iter = (state == RUN) && (cnt == 6'd31);

  // Add M only when the current multiplier bit is set; the carry-out becomes
  // the new top bit so the full 64-bit product is kept.
  assign add_y = p[0] ? m : 32'd0;

  cla u_cla (
    .x    (p[63:32]),
    .y    (add_y),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign p_nxt = {add_cout, add_sum, p[31:1]};

`ifdef SHIFT_ADD_MUL_SIGNED_EN
  logic neg;
  // Magnitudes as 32-bit unsigned: 0x80000000 stays 0x80000000 (2^31).
  assign a_ld   = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
  assign b_ld   = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
  assign result = neg ? (~p_nxt + 64'd1) : p_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      neg <= bus.a[31] ^ bus.b[31];
    end
  end
`else
  assign a_ld   = bus.a;
  assign b_ld   = bus.b;
  assign result = p_nxt;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.busy = (state == RUN) || (state == DONE);
    bus.done = (state == DONE);
  end

  assign bus.product = product_q;

  // Datapath: operands are only written at accept and during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m         <= '0;
      p         <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m   <= a_ld;
            p   <= {32'd0, b_ld};
            cnt <= '0;
          end
        end
        RUN: begin
          p   <= p_nxt;
          cnt <= cnt + 6'd1;
          if (last_iter) product_q <= result;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_mul.sv
// tb/tb_shift_add_mul.sv - self-checking bench for shift_add_mul
// Ports exercised: clk, rst_n and all shift_add_mul_if signals.
// Build option: SHIFT_ADD_MUL_SIGNED_EN selects the signed vector table/model.
module tb_shift_add_mul;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  shift_add_mul_if bus ();

  shift_add_mul dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
`ifdef SHIFT_ADD_MUL_SIGNED_EN
    longint sx;
    longint sy;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    return 64'(sx * sy);
`else
    return {32'd0, x} * {32'd0, y};
`endif
  endfunction

  // One complete operation with start pulsed at E0; checks busy at E0,
  // done exactly at E32, product, and the return to idle at E33.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input logic [63:0] prev, input string nm);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, " busy@E0"}, 64'(bus.busy), 64'd1);
    chk({nm, " held product@E0"}, bus.product, prev);
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'd32);
    chk({nm, " product"}, bus.product, exp);
    @(posedge clk); #1;
    chk({nm, " done@E33"}, 64'(bus.done), 64'd0);
    chk({nm, " busy@E33"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] last;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] rexp;
    int          dones;
    int          d1;
    int          d2;
    logic [63:0] p1;
    logic [63:0] p2;

`ifdef SHIFT_ADD_MUL_SIGNED_EN
    vecs[0] = '{32'hFFFFFFFD, 32'd5,        64'hFFFFFFFFFFFFFFF1};
    vecs[1] = '{32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[2] = '{32'd0,        32'hFFFFFFFF, 64'd0};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1};
    vecs[4] = '{32'h80000000, 32'd1,        64'hFFFFFFFF80000000};
    vecs[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF80000001};
`else
    vecs[0] = '{32'd3,        32'd5,        64'h000000000000000F};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[2] = '{32'd0,        32'hDEADBEEF, 64'd0};
    vecs[3] = '{32'hDEADBEEF, 32'd0,        64'd0};
    vecs[4] = '{32'h80000000, 32'd2,        64'h0000000100000000};
    vecs[5] = '{32'hFFFFFFFF, 32'd1,        64'h00000000FFFFFFFF};
`endif

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset product", bus.product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    last = 64'd0;
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp, last, $sformatf("vec%0d", i));
      last = vecs[i].exp;
    end

    // start held high while busy must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd7; bus.b = 32'd6;
    @(posedge clk); #1;                       // E0
    bus.start = 1'b0;
    dones = 0;
    for (int e = 1; e <= 72; e++) begin
      if (e == 5) begin bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9; end
      @(posedge clk); #1;                     // edge e
      if (e == 20) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        chk("ignore start done edge", 64'(e), 64'd32);
        chk("ignore start product", bus.product, 64'h2A);
      end
    end
    chk("ignore start done count", 64'(dones), 64'd1);
    chk("ignore start idle", 64'(bus.busy), 64'd0);

    // reset during RUN aborts the operation
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd100;
    @(posedge clk); #1;                       // E0
    bus.start = 1'b0;
    dones = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("abort no early done", 64'(dones), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort product", bus.product, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort held product", bus.product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'd2, 32'd2, 64'd4, 64'd0, "after reset");

    // back-to-back with start held continuously
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd0; bus.b = 32'h12345678;
    @(posedge clk); #1;                       // E0
    bus.a = 32'd1; bus.b = 32'd2;
    d1 = -1; d2 = -1; p1 = '1; p2 = '1;
    for (int e = 1; e <= 70; e++) begin
      @(posedge clk); #1;
      if (e == 33) chk("b2b idle@E33", 64'(bus.busy), 64'd0);
      if (e == 34) begin
        chk("b2b accept@E34", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
      end
      if (bus.done) begin
        if (d1 < 0) begin d1 = e; p1 = bus.product; end
        else if (d2 < 0) begin d2 = e; p2 = bus.product; end
      end
    end
    chk("b2b first done edge", 64'(d1), 64'd32);
    chk("b2b first product", p1, 64'd0);
    chk("b2b second done edge", 64'(d2), 64'd66);
    chk("b2b second product", p2, 64'd2);
    last = 64'd2;

    // Randomized against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) ra = 32'h80000000;
      if (i % 7 == 3) rb = 32'hFFFFFFFF;
      rexp = model(ra, rb);
      do_op(ra, rb, rexp, last, $sformatf("rand%0d", i));
      last = rexp;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
